// File: rtl/imem_boot_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// imem_boot_ctrl - clear / load / run sequencer for the single-port instruction
// memory; optional IMEM_CTRL_BOUNDS_EN adds NOP-on-out-of-range + fetch_fault.  Rev 1.0
// ---------------------------------------------------------------------------
module imem_boot_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int CLEAR_WORDS = 64
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_valid,
  output logic [31:0]       instruction,
  output logic              core_stall,
  output logic [ADDR_W:0]   load_count,
  output logic              boot_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef IMEM_CTRL_BOUNDS_EN
  ,
  output logic              fetch_fault
`endif
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;
  localparam logic [31:0]       c_NOP      = 32'h0000_0013;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W:0]     r_load_count;
  logic                r_boot_err;
  logic                r_fetch_pend;
  logic [31:0]         r_instr_hold;

  logic                w_in_run;
  logic                w_squash;
  logic                w_fetch_go;
  logic                w_beat;
  logic                w_last_addr;
  logic [ADDR_W-1:0]   w_fetch_idx;
  logic [31:0]         w_fetch_data;
  logic                w_unused_pc;

  assign w_in_run    = (r_state == S_RUN);
  assign w_squash    = w_in_run & load_start;
  assign w_fetch_go  = w_in_run & fetch_req & ~load_start;
  assign w_beat      = (r_state == S_LOAD) & load_valid;
  assign w_last_addr = (r_load_count[ADDR_W-1:0] == c_ADDR_MAX);
  assign w_fetch_idx = fetch_pc[ADDR_W+1:2];

`ifdef IMEM_CTRL_BOUNDS_EN
  logic r_fetch_nop;
  logic w_fetch_oob;

  // Outside the loaded image or above the physical array: answer with a NOP.
  assign w_fetch_oob  = (|(fetch_pc >> (ADDR_W + 2))) | ({1'b0, w_fetch_idx} >= r_load_count);
  assign w_fetch_data = r_fetch_nop ? c_NOP : mem_rdata;
  assign fetch_fault  = fetch_valid & r_fetch_nop;
  assign w_unused_pc  = ^fetch_pc[1:0];

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      r_fetch_nop <= 1'b0;
    end else begin
      r_fetch_nop <= w_fetch_go & w_fetch_oob;
    end
  end
`else
  assign w_fetch_data = mem_rdata;
  assign w_unused_pc  = ^{fetch_pc[31:ADDR_W+2], fetch_pc[1:0]};
`endif

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      r_state      <= S_CLEAR;
      r_clr_cnt    <= '0;
      r_load_count <= '0;
      r_boot_err   <= 1'b0;
      r_fetch_pend <= 1'b0;
      r_instr_hold <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_cnt    <= (r_state == S_CLEAR) ? r_clr_cnt + 1'b1 : '0;
      r_fetch_pend <= w_fetch_go;
      if (w_squash) begin
        r_load_count <= '0;
      end else if (w_beat) begin
        r_load_count <= r_load_count + 1'b1;
      end
      if (w_beat && w_last_addr && !load_last) begin
        r_boot_err <= 1'b1;
      end
      if (fetch_valid) begin
        r_instr_hold <= w_fetch_data;
      end
    end
  end

  // Only the current state drives mem_addr, so write and fetch never collide.
  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    load_ready  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = r_clr_cnt;
        if (r_clr_cnt == c_CLR_LAST) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        mem_addr   = r_load_count[ADDR_W-1:0];
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
          if (load_last || w_last_addr) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        mem_addr = w_fetch_idx;
        if (load_start) begin
          w_state_nxt = S_CLEAR;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // A fetch returning in the reload cycle is squashed before it reaches the core.
  assign fetch_valid = r_fetch_pend & ~w_squash;
  assign instruction = fetch_valid ? w_fetch_data : r_instr_hold;
  assign core_stall  = ~w_in_run;
  assign load_count  = r_load_count;
  assign boot_err    = r_boot_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_boot_ctrl - scoreboard bench for imem_boot_ctrl (memory model inside).  Rev 1.0
// ---------------------------------------------------------------------------
module tb_imem_boot_ctrl;
  localparam int          ADDR_W      = 10;
  localparam int          CLEAR_WORDS = 64;
  localparam int          DEPTH       = 1 << ADDR_W;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic              SYS_clk = 1'b0;
  logic              SYS_reset;
  logic              load_start, load_valid, load_last, load_ready;
  logic [31:0]       load_data;
  logic              fetch_req, fetch_valid;
  logic [31:0]       fetch_pc, instruction;
  logic              core_stall, boot_err, mem_we;
  logic [ADDR_W:0]   load_count;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
`ifdef IMEM_CTRL_BOUNDS_EN
  logic              fetch_fault;
`endif

  logic [31:0] mem    [DEPTH];
  logic [31:0] golden [DEPTH];
  int          g_count = 0;
  logic [31:0] img [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
  logic [32:0] q_exp [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .CLEAR_WORDS(CLEAR_WORDS)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .instruction(instruction), .core_stall(core_stall), .load_count(load_count),
    .boot_err(boot_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_CTRL_BOUNDS_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  always #5 SYS_clk = ~SYS_clk;

  // Single-port array with registered read data.
  always @(posedge SYS_clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  function automatic logic [32:0] exp_fetch(input logic [31:0] pc);
    logic [ADDR_W-1:0] idx;
    idx = pc[ADDR_W+1:2];
`ifdef IMEM_CTRL_BOUNDS_EN
    if ((pc >> (ADDR_W + 2)) != 0 || int'(idx) >= g_count) return {1'b1, NOP};
`endif
    return {1'b0, golden[idx]};
  endfunction

  task automatic golden_clear;
    for (int w = 0; w < CLEAR_WORDS; w++) golden[w] = 32'h0;
    g_count = 0;
  endtask

  task automatic test_reset;
    SYS_reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    load_last = 1'b0; fetch_req = 1'b0; fetch_pc = '0;
    repeat (2) @(posedge SYS_clk);
    #1;
    @(negedge SYS_clk);
    n_checks++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", core_stall); end
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", load_ready); end
    n_checks++; if (load_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", load_count); end
    n_checks++; if (boot_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", boot_err); end
    n_checks++; if (fetch_valid !== 1'b0 || instruction !== 32'h0) begin
      n_fail++; $display("FAIL reset_fetch: got v=%b i=%h want v=0 i=0", fetch_valid, instruction); end
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== '0) begin
      n_fail++; $display("FAIL reset_clear_addr: got we=%b a=%0d want we=1 a=0", mem_we, mem_addr); end
    golden_clear();
  endtask

  task automatic test_load_image;
    int n;
    @(posedge SYS_clk); #1; SYS_reset = 1'b1;
    n = 0;
    for (int i = 0; i < 4 * CLEAR_WORDS; i++) begin
      @(negedge SYS_clk);
      if (load_ready) break;
      n++;
    end
    n_checks++; if (n != CLEAR_WORDS) begin n_fail++; $display("FAIL clear_cycles: got %0d want %0d", n, CLEAR_WORDS); end
    for (int i = 0; i < 3; i++) begin
      @(posedge SYS_clk); #1;
      load_valid = 1'b1; load_data = img[i]; load_last = (i == 2);
      golden[i] = img[i];
      @(negedge SYS_clk);
      n_checks++;
      if (load_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(i) || core_stall !== 1'b1) begin
        n_fail++; $display("FAIL load_beat%0d: got rdy=%b we=%b a=%0d stall=%b want 1 1 %0d 1",
                           i, load_ready, mem_we, mem_addr, core_stall, i); end
    end
    @(posedge SYS_clk); #1; load_valid = 1'b0; load_last = 1'b0;
    g_count = 3;
    @(negedge SYS_clk);
    n_checks++; if (core_stall !== 1'b0 || load_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_run_entry: got stall=%b rdy=%b want 0 0", core_stall, load_ready); end
    n_checks++; if (load_count !== 11'd3 || boot_err !== 1'b0) begin
      n_fail++; $display("FAIL load_count3: got cnt=%0d err=%b want 3 0", load_count, boot_err); end
    for (int w = 0; w < CLEAR_WORDS; w++) begin
      n_checks++; if (mem[w] !== golden[w]) begin
        n_fail++; $display("FAIL mem_word%0d: got %h want %h", w, mem[w], golden[w]); end
    end
  endtask

  task automatic test_fetch_seq;
    logic [31:0] pcs [$];
    logic [32:0] e;
    logic        want;
    pcs = '{32'h0, 32'h4, 32'h8, 32'h7, 32'h0000_1008};
    for (int i = 0; i <= pcs.size(); i++) begin
      @(posedge SYS_clk); #1;
      if (i < pcs.size()) begin
        fetch_req = 1'b1; fetch_pc = pcs[i]; q_exp.push_back(exp_fetch(pcs[i]));
      end else fetch_req = 1'b0;
      // mem_we must stay low in RUN even with a stray loader word
      load_valid = (i == 1);
      @(negedge SYS_clk);
      want = (i > 0);
      n_checks++; if (fetch_valid !== want || mem_we !== 1'b0) begin
        n_fail++; $display("FAIL fetch_valid%0d: got v=%b we=%b want v=%b we=0", i, fetch_valid, mem_we, want); end
      if (fetch_valid && q_exp.size() > 0) begin
        e = q_exp.pop_front();
        n_checks++; if (instruction !== e[31:0]) begin
          n_fail++; $display("FAIL fetch_data%0d: got %h want %h", i, instruction, e[31:0]); end
`ifdef IMEM_CTRL_BOUNDS_EN
        n_checks++; if (fetch_fault !== e[32]) begin
          n_fail++; $display("FAIL fetch_fault%0d: got %b want %b", i, fetch_fault, e[32]); end
`endif
      end
    end
    load_valid = 1'b0;
    e = exp_fetch(pcs[pcs.size()-1]);
    @(posedge SYS_clk); #1;
    @(negedge SYS_clk);
    n_checks++; if (fetch_valid !== 1'b0 || instruction !== e[31:0] || q_exp.size() != 0) begin
      n_fail++; $display("FAIL fetch_hold: got v=%b i=%h q=%0d want 0 %h 0", fetch_valid, instruction, q_exp.size(), e[31:0]); end
    q_exp.delete();
  endtask

  task automatic test_reload_squash;
    int n;
    @(posedge SYS_clk); #1; fetch_req = 1'b1; fetch_pc = 32'h4;
    @(posedge SYS_clk); #1; load_start = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h8;
    @(negedge SYS_clk);
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL squash_inflight: got %b want 0", fetch_valid); end
    @(posedge SYS_clk); #1; load_start = 1'b0; fetch_req = 1'b0;
    @(negedge SYS_clk);
    n_checks++; if (fetch_valid !== 1'b0 || core_stall !== 1'b1 || load_ready !== 1'b0) begin
      n_fail++; $display("FAIL squash_state: got v=%b stall=%b rdy=%b want 0 1 0", fetch_valid, core_stall, load_ready); end
    n_checks++; if (load_count !== '0 || mem_we !== 1'b1 || mem_addr !== '0) begin
      n_fail++; $display("FAIL reload_clear: got cnt=%0d we=%b a=%0d want 0 1 0", load_count, mem_we, mem_addr); end
    golden_clear();
    n = 1;
    for (int i = 0; i < 4 * CLEAR_WORDS; i++) begin
      @(negedge SYS_clk);
      if (load_ready) break;
      n++;
    end
    n_checks++; if (n != CLEAR_WORDS) begin n_fail++; $display("FAIL reload_clear_cycles: got %0d want %0d", n, CLEAR_WORDS); end
  endtask

  task automatic test_overflow;
    int          bad;
    logic [32:0] e;
    bad = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      @(posedge SYS_clk); #1;
      load_valid = 1'b1; load_data = 32'hA000_0000 | 32'(i); load_last = 1'b0;
      @(negedge SYS_clk);
      if (i < DEPTH) begin
        golden[i] = load_data;
        if (load_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(i)) bad++;
      end
      if (i == DEPTH - 1) begin
        n_checks++; if (boot_err !== 1'b0 || core_stall !== 1'b1) begin
          n_fail++; $display("FAIL ovf_lastbeat: got err=%b stall=%b want 0 1", boot_err, core_stall); end
      end
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ovf_beats: got %0d bad beats want 0", bad); end
    n_checks++; if (load_ready !== 1'b0 || mem_we !== 1'b0 || core_stall !== 1'b0) begin
      n_fail++; $display("FAIL ovf_extra: got rdy=%b we=%b stall=%b want 0 0 0", load_ready, mem_we, core_stall); end
    n_checks++; if (boot_err !== 1'b1 || load_count !== 11'(DEPTH)) begin
      n_fail++; $display("FAIL ovf_status: got err=%b cnt=%0d want 1 %0d", boot_err, load_count, DEPTH); end
    load_valid = 1'b0;
    g_count = DEPTH;
    bad = 0;
    for (int w = 0; w < DEPTH; w++) if (mem[w] !== golden[w]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ovf_mem: got %0d bad words want 0", bad); end
    @(posedge SYS_clk); #1; fetch_req = 1'b1; fetch_pc = 32'(4 * (DEPTH - 1));
    q_exp.push_back(exp_fetch(fetch_pc));
    @(posedge SYS_clk); #1; fetch_req = 1'b0;
    @(negedge SYS_clk);
    n_checks++;
    if (fetch_valid !== 1'b1 || q_exp.size() == 0) begin
      n_fail++; $display("FAIL ovf_fetch_valid: got %b want 1", fetch_valid);
    end else begin
      e = q_exp.pop_front();
      if (instruction !== e[31:0]) begin
        n_fail++; $display("FAIL ovf_fetch_data: got %h want %h", instruction, e[31:0]); end
    end
    q_exp.delete();
    @(posedge SYS_clk); #1; load_start = 1'b1;
    @(posedge SYS_clk); #1; load_start = 1'b0;
    @(negedge SYS_clk);
    n_checks++; if (boot_err !== 1'b1 || core_stall !== 1'b1 || load_count !== '0) begin
      n_fail++; $display("FAIL err_sticky: got err=%b stall=%b cnt=%0d want 1 1 0", boot_err, core_stall, load_count); end
    golden_clear();
    for (int i = 0; i < 4 * CLEAR_WORDS; i++) begin
      @(negedge SYS_clk);
      if (load_ready) break;
    end
  endtask

  task automatic test_reset_mid_load;
    int n;
    for (int i = 0; i < 5; i++) begin
      @(posedge SYS_clk); #1;
      load_valid = 1'b1; load_data = 32'hB000_0000 | 32'(i); load_last = 1'b0;
      golden[i] = load_data;
    end
    @(negedge SYS_clk);
    n_checks++; if (load_count !== 11'd4) begin n_fail++; $display("FAIL midload_count: got %0d want 4", load_count); end
    @(posedge SYS_clk); #1; load_valid = 1'b0; SYS_reset = 1'b0;
    @(posedge SYS_clk); #1; SYS_reset = 1'b1;
    @(negedge SYS_clk);
    n_checks++; if (core_stall !== 1'b1 || load_ready !== 1'b0 || load_count !== '0 || boot_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_status: got stall=%b rdy=%b cnt=%0d err=%b want 1 0 0 0",
                         core_stall, load_ready, load_count, boot_err); end
    n_checks++; if (fetch_valid !== 1'b0 || instruction !== 32'h0) begin
      n_fail++; $display("FAIL midreset_fetch: got v=%b i=%h want 0 0", fetch_valid, instruction); end
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== '0) begin
      n_fail++; $display("FAIL midreset_addr0: got we=%b a=%0d want 1 0", mem_we, mem_addr); end
    @(negedge SYS_clk);
    n_checks++; if (mem_addr !== ADDR_W'(1)) begin n_fail++; $display("FAIL midreset_addr1: got %0d want 1", mem_addr); end
    golden_clear();
    n = 2;
    for (int i = 0; i < 4 * CLEAR_WORDS; i++) begin
      @(negedge SYS_clk);
      if (load_ready) break;
      n++;
    end
    n_checks++; if (n != CLEAR_WORDS) begin n_fail++; $display("FAIL midreset_clear_cycles: got %0d want %0d", n, CLEAR_WORDS); end
  endtask

  task automatic test_bounds;
    logic [31:0] pcs [$];
    logic [32:0] e;
    int          bad;
    for (int i = 0; i < 3; i++) begin
      @(posedge SYS_clk); #1;
      load_valid = 1'b1; load_data = img[i]; load_last = (i == 2);
      golden[i] = img[i];
    end
    @(posedge SYS_clk); #1; load_valid = 1'b0; load_last = 1'b0;
    g_count = 3;
    @(negedge SYS_clk);
    bad = 0;
    for (int w = 0; w < 2 * CLEAR_WORDS; w++) if (mem[w] !== golden[w]) bad++;
    n_checks++; if (bad != 0 || load_count !== 11'd3) begin
      n_fail++; $display("FAIL reboot_mem: got %0d bad words cnt=%0d want 0 3", bad, load_count); end
    pcs = '{32'h4, 32'hC, 32'h0000_1004};
    for (int i = 0; i <= pcs.size(); i++) begin
      @(posedge SYS_clk); #1;
      if (i < pcs.size()) begin
        fetch_req = 1'b1; fetch_pc = pcs[i]; q_exp.push_back(exp_fetch(pcs[i]));
      end else fetch_req = 1'b0;
      @(negedge SYS_clk);
      if (i > 0) begin
        n_checks++;
        if (fetch_valid !== 1'b1 || q_exp.size() == 0) begin
          n_fail++; $display("FAIL bnd_valid%0d: got %b want 1", i, fetch_valid);
        end else begin
          e = q_exp.pop_front();
          if (instruction !== e[31:0]) begin
            n_fail++; $display("FAIL bnd_data%0d: got %h want %h", i, instruction, e[31:0]); end
`ifdef IMEM_CTRL_BOUNDS_EN
          n_checks++; if (fetch_fault !== e[32]) begin
            n_fail++; $display("FAIL bnd_fault%0d: got %b want %b", i, fetch_fault, e[32]); end
`endif
        end
      end
    end
    q_exp.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_image();
    test_fetch_seq();
    test_reload_squash();
    test_overflow();
    test_reset_mid_load();
    test_bounds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
